// File: rtl/io_mmio_pkg.sv
// Shared constants for the memory-mapped I/O block: address map, UART_CTL bit positions, reset patterns.
// No logic, no latency.
// No flow control.
package io_mmio_pkg;

    localparam logic [15:0] ADDR_LEDR_LO  = 16'hFF00;
    localparam logic [15:0] ADDR_LEDR_HI  = 16'hFF01;
    localparam logic [15:0] ADDR_LEDG     = 16'hFF02;
    localparam logic [15:0] ADDR_SW_LO    = 16'hFF03;
    localparam logic [15:0] ADDR_SW_HI    = 16'hFF04;
    localparam logic [15:0] ADDR_KEY      = 16'hFF05;
    localparam logic [15:0] ADDR_KEY_EVT  = 16'hFF06;
    localparam logic [15:0] ADDR_UART_TXD = 16'hFF07;
    localparam logic [15:0] ADDR_UART_RXD = 16'hFF08;
    localparam logic [15:0] ADDR_UART_CTL = 16'hFF09;
    localparam logic [15:0] ADDR_IRQ_EN   = 16'hFF0A;
    localparam logic [15:0] ADDR_SEG_BASE = 16'hFF10;

    localparam int CTL_RX_NONEMPTY = 0;
    localparam int CTL_TX_NONFULL  = 1;
    localparam int CTL_TX_BUSY     = 2;
    localparam int CTL_RX_OVF      = 3;
    localparam int CTL_TX_OVF      = 4;
    localparam int CTL_TX_EMPTY    = 5;

    // All segments off (segments are active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_t;

    // Bus address of seven-segment digit i
    function automatic logic [15:0] seg_addr(input int i);
        return ADDR_SEG_BASE + 16'(i);
    endfunction

endpackage

// File: rtl/io_mmio_if.sv
// CPU data-bus port of the I/O block: address, strobes, write data, registered read data.
// Read data appears one cycle after the read strobe.
// No backpressure; every strobe is accepted.
interface io_mmio_if;
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [7:0]  di;
    logic [7:0]  dout;

    modport master (output addr, we, re, di, input dout);
    modport slave  (input addr, we, re, di, output dout);
endinterface

// File: rtl/io_mmio_fifo.sv
// Synchronous FIFO, depth 2**AW, head visible combinationally while non-empty.
// Push/pop take effect at the next edge.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module io_mmio_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer MSB distinguishes full from empty when the low bits match
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer advance
    always_comb begin
        wptr_d = wr_en ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = rd_en ? rptr_q + PTR_ONE : rptr_q;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= dat_i;
    end

endmodule

// File: rtl/io_mmio.sv
// MMIO peripheral: LEDs, seven-segment digits, synchronised switches/keys with sticky press events, buffered UART.
// Writes land at the next edge; read data is registered, valid one cycle after the read strobe.
// TX/RX FIFOs drop on full and flag overflow; optional level interrupt under IO_MMIO_IRQ_EN.
module io_mmio
    import io_mmio_pkg::*;
#(
    parameter int NUM_SEG  = 4,
    parameter int NUM_LEDR = 10,
    parameter int NUM_LEDG = 8,
    parameter int NUM_SW   = 10,
    parameter int NUM_KEY  = 4,
    parameter int FIFO_AW  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    io_mmio_if.slave              bus,
    input  logic [NUM_SW-1:0]     switches_i,
    input  logic [NUM_KEY-1:0]    keys_i,
    output logic [NUM_LEDR-1:0]   ledr_o,
    output logic [NUM_LEDG-1:0]   ledg_o,
    output logic [7*NUM_SEG-1:0]  seg_o,
    input  logic [7:0]            uart_rx_data_i,
    input  logic                  uart_rx_done_i,
    output logic [7:0]            uart_tx_data_o,
    output logic                  uart_tx_start_o,
    input  logic                  uart_tx_done_i,
    input  logic [7:0]            boot_tx_data_i,
    input  logic                  boot_transmit_i,
    input  logic                  booting_i,
    output logic                  irq_o
);

    // ---------------- bus decode ----------------
    logic rd_req;
    logic wr_ledr_lo, wr_ledr_hi, wr_ledg, wr_key_evt, wr_txd, wr_ctl;
    logic rd_rxd;

    // A simultaneous write wins: the strobe pair is treated as a write only
    assign rd_req     = bus.re && !bus.we;
    assign wr_ledr_lo = bus.we && (bus.addr == ADDR_LEDR_LO);
    assign wr_ledr_hi = bus.we && (bus.addr == ADDR_LEDR_HI);
    assign wr_ledg    = bus.we && (bus.addr == ADDR_LEDG);
    assign wr_key_evt = bus.we && (bus.addr == ADDR_KEY_EVT);
    assign wr_txd     = bus.we && (bus.addr == ADDR_UART_TXD);
    assign wr_ctl     = bus.we && (bus.addr == ADDR_UART_CTL);
    assign rd_rxd     = rd_req && (bus.addr == ADDR_UART_RXD);

    // ---------------- input synchronisers ----------------
    logic [NUM_SW-1:0]  sw_s1_q, sw_s2_q;
    logic [NUM_KEY-1:0] key_s1_q, key_s2_q, key_s3_q;
    logic [NUM_KEY-1:0] key_press;

    // Two-flop synchronisers; key flops reset to the released (high) pin level so reset never fakes a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '1;
            key_s2_q <= '1;
            key_s3_q <= '1;
        end else begin
            sw_s1_q  <= switches_i;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= keys_i;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
        end
    end

    // Press = synchronised pin fell from 1 to 0
    assign key_press = key_s3_q & ~key_s2_q;

    // ---------------- UART FIFOs ----------------
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;

    // TX bytes arriving on a full FIFO are dropped even if the FSM pops this cycle
    assign tx_push = wr_txd && !tx_full;
    assign rx_pop  = rd_rxd && !rx_empty;

    io_mmio_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .dat_i   (bus.di),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    io_mmio_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (uart_rx_done_i),
        .dat_i   (uart_rx_data_i),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // ---------------- TX FSM ----------------
    tx_state_t  tx_state_q, tx_state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_busy;

    // Next state: launch one byte at a time, never while the boot loader owns the line
    always_comb begin
        tx_state_d = tx_state_q;
        tx_start_d = 1'b0;
        tx_hold_d  = tx_hold_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !booting_i) begin
                    tx_pop     = 1'b1;
                    tx_start_d = 1'b1;
                    tx_hold_d  = tx_head;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (uart_tx_done_i) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // FSM state, start pulse and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_hold_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_start_q <= tx_start_d;
            tx_hold_q  <= tx_hold_d;
        end
    end

    assign tx_busy         = (tx_state_q != TX_IDLE);
    assign uart_tx_start_o = booting_i ? boot_transmit_i : tx_start_q;
    assign uart_tx_data_o  = booting_i ? boot_tx_data_i  : tx_hold_q;

    // ---------------- register file ----------------
    logic [NUM_LEDR-1:0]     ledr_q, ledr_d;
    logic [NUM_LEDG-1:0]     ledg_q, ledg_d;
    logic [NUM_SEG-1:0][6:0] seg_q, seg_d;
    logic [NUM_KEY-1:0]      key_evt_q, key_evt_d;
    logic                    rx_ovf_q, rx_ovf_d;
    logic                    tx_ovf_q, tx_ovf_d;
    logic [7:0]              dout_q, dout_d;

    // Write side: LED/SEG updates, sticky event and overflow flags (a set beats a same-cycle clear)
    always_comb begin
        ledr_d = ledr_q;
        for (int i = 0; i < NUM_LEDR; i++) begin
            if ((i < 8) ? wr_ledr_lo : wr_ledr_hi) ledr_d[i] = bus.di[i % 8];
        end
        ledg_d = ledg_q;
        for (int i = 0; i < NUM_LEDG; i++) begin
            if (wr_ledg) ledg_d[i] = bus.di[i];
        end
        seg_d = seg_q;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (bus.we && (bus.addr == seg_addr(i))) seg_d[i] = bus.di[6:0];
        end
        key_evt_d = key_evt_q;
        if (wr_key_evt) key_evt_d = key_evt_q & ~bus.di[NUM_KEY-1:0];
        key_evt_d = key_evt_d | key_press;
        rx_ovf_d = (rx_ovf_q && !(wr_ctl && bus.di[CTL_RX_OVF]))
                   || (uart_rx_done_i && rx_full && !rx_pop);
        tx_ovf_d = (tx_ovf_q && !(wr_ctl && bus.di[CTL_TX_OVF]))
                   || (wr_txd && tx_full);
    end

    // ---------------- optional interrupt ----------------
`ifdef IO_MMIO_IRQ_EN
    logic       wr_irq_en;
    logic [3:0] irq_en_q, irq_src;
    logic       irq_q;

    assign wr_irq_en = bus.we && (bus.addr == ADDR_IRQ_EN);
    assign irq_src   = {rx_ovf_q || tx_ovf_q, |key_evt_q, tx_empty, !rx_empty};

    // Enable register and registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_irq_en) irq_en_q <= bus.di[3:0];
            irq_q <= |(irq_en_q & irq_src);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // ---------------- read side ----------------
    logic [15:0] ledr_ext, sw_ext;
    logic [7:0]  ledg_ext, key_ext, evt_ext, ctl_rd;

    // Zero-extend every field so unused high bits read back as 0
    always_comb begin
        ledr_ext = '0;
        ledr_ext[NUM_LEDR-1:0] = ledr_q;
        sw_ext = '0;
        sw_ext[NUM_SW-1:0] = sw_s2_q;
        ledg_ext = '0;
        ledg_ext[NUM_LEDG-1:0] = ledg_q;
        key_ext = '0;
        key_ext[NUM_KEY-1:0] = ~key_s2_q;
        evt_ext = '0;
        evt_ext[NUM_KEY-1:0] = key_evt_q;
        ctl_rd = '0;
        ctl_rd[CTL_RX_NONEMPTY] = !rx_empty;
        ctl_rd[CTL_TX_NONFULL]  = !tx_full;
        ctl_rd[CTL_TX_BUSY]     = tx_busy;
        ctl_rd[CTL_RX_OVF]      = rx_ovf_q;
        ctl_rd[CTL_TX_OVF]      = tx_ovf_q;
        ctl_rd[CTL_TX_EMPTY]    = tx_empty;
    end

    // Read mux; unmapped addresses return 0, the output holds when there is no read
    always_comb begin
        dout_d = dout_q;
        if (rd_req) begin
            dout_d = '0;
            case (bus.addr)
                ADDR_LEDR_LO:  dout_d = ledr_ext[7:0];
                ADDR_LEDR_HI:  dout_d = ledr_ext[15:8];
                ADDR_LEDG:     dout_d = ledg_ext;
                ADDR_SW_LO:    dout_d = sw_ext[7:0];
                ADDR_SW_HI:    dout_d = sw_ext[15:8];
                ADDR_KEY:      dout_d = key_ext;
                ADDR_KEY_EVT:  dout_d = evt_ext;
                ADDR_UART_RXD: dout_d = rx_empty ? 8'h00 : rx_head;
                ADDR_UART_CTL: dout_d = ctl_rd;
`ifdef IO_MMIO_IRQ_EN
                ADDR_IRQ_EN:   dout_d = {4'b0000, irq_en_q};
`endif
                default:       dout_d = '0;
            endcase
            for (int i = 0; i < NUM_SEG; i++) begin
                if (bus.addr == seg_addr(i)) dout_d = {1'b0, seg_q[i]};
            end
        end
    end

    // Register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            seg_q     <= {NUM_SEG{SEG_BLANK}};
            key_evt_q <= '0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            seg_q     <= seg_d;
            key_evt_q <= key_evt_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dout = dout_q;
    assign ledr_o   = ledr_q;
    assign ledg_o   = ledg_q;
    assign seg_o    = seg_q;

endmodule

// File: tb/tb_io_mmio.sv
// Self-checking bench for io_mmio: randomized data against a queue-based reference model.
// Bus ops complete in one cycle each; read data is sampled just after the capturing edge.
// UART start pulses are logged by a monitor on the falling edge.
module tb_io_mmio;
    import io_mmio_pkg::*;

    localparam int DEPTH = 8;
`ifdef IO_MMIO_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_mmio_if bus ();

    logic [9:0]  switches;
    logic [3:0]  keys;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [27:0] seg;
    logic [7:0]  rx_data, tx_data, boot_data;
    logic        rx_done, tx_start, tx_done, boot_tx, booting, irq;

    io_mmio dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .switches_i      (switches),
        .keys_i          (keys),
        .ledr_o          (ledr),
        .ledg_o          (ledg),
        .seg_o           (seg),
        .uart_rx_data_i  (rx_data),
        .uart_rx_done_i  (rx_done),
        .uart_tx_data_o  (tx_data),
        .uart_tx_start_o (tx_start),
        .uart_tx_done_i  (tx_done),
        .boot_tx_data_i  (boot_data),
        .boot_transmit_i (boot_tx),
        .booting_i       (booting),
        .irq_o           (irq)
    );

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [6:0] seg_m [4];
    bit         tx_ovf_m, rx_ovf_m;
    logic [7:0] start_log[$];

    int n_total = 0;
    int n_pass  = 0;

    // Every start pulse seen on the UART side
    always @(negedge clk) begin
        if (rst_n && tx_start) start_log.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.addr = a; bus.di = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.addr = a; bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        d = bus.dout;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Wait (bounded) for the next logged start pulse
    task automatic wait_start(output bit seen, output logic [7:0] d);
        seen = 1'b0;
        d = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (start_log.size() > 0) begin
                seen = 1'b1;
                d = start_log.pop_front();
            end else begin
                tick();
            end
        end
    endtask

    function automatic logic [7:0] ctl_exp();
        return {2'b00, txq.size() == 0, tx_ovf_m, rx_ovf_m, 1'b0,
                txq.size() < DEPTH, rxq.size() != 0};
    endfunction

    initial begin
        logic [7:0]  d, b, exp;
        logic [15:0] r;
        logic [27:0] seg_exp;
        bit          seen;
        int          k;

        bus.addr = '0; bus.di = '0; bus.we = 1'b0; bus.re = 1'b0;
        switches = '0; keys = 4'hF; rx_data = '0; rx_done = 1'b0;
        tx_done = 1'b0; boot_data = '0; boot_tx = 1'b0; booting = 1'b0;
        for (int i = 0; i < 4; i++) seg_m[i] = 7'h7F;
        tx_ovf_m = 1'b0; rx_ovf_m = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ledr", ledr, 0);
        check("rst_ledg", ledg, 0);
        check("rst_seg", seg, 28'hFFFFFFF);
        check("rst_dout", bus.dout, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        tick();
        rd(ADDR_UART_CTL, d); check("rst_ctl", d, ctl_exp());

        // Red LEDs: directed then random; high bits beyond width read 0
        wr(ADDR_LEDR_LO, 8'hA5); wr(ADDR_LEDR_HI, 8'h03);
        rd(ADDR_LEDR_LO, d); check("ledr_lo", d, 8'hA5);
        rd(ADDR_LEDR_HI, d); check("ledr_hi", d, 8'h03);
        check("ledr_pins", ledr, 10'h3A5);
        repeat (2) tick();
        check("dout_hold", bus.dout, 8'h03);
        r = 16'($urandom);
        wr(ADDR_LEDR_LO, r[7:0]); wr(ADDR_LEDR_HI, r[15:8]);
        rd(ADDR_LEDR_HI, d); check("ledr_hi_rand", d, {6'b0, r[9:8]});
        check("ledr_pins_rand", ledr, r[9:0]);
        b = 8'($urandom);
        wr(ADDR_LEDG, b);
        rd(ADDR_LEDG, d); check("ledg_read", d, b);
        check("ledg_pins", ledg, b);

        // Seven-segment digits
        wr(seg_addr(3), 8'h40); seg_m[3] = 7'h40;
        check("seg3_pins", seg[27:21], 7'h40);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wr(seg_addr(i), b);
            seg_m[i] = b[6:0];
        end
        for (int i = 0; i < 4; i++) begin
            rd(seg_addr(i), d); check("seg_read", d, {1'b0, seg_m[i]});
        end
        for (int i = 0; i < 4; i++) seg_exp[7*i +: 7] = seg_m[i];
        check("seg_pins", seg, seg_exp);
        rd(16'h1234, d); check("unmapped", d, 0);
        rd(ADDR_IRQ_EN, d); check("irq_en_reset", d, 0);

        // Switches through the synchroniser
        r = 16'($urandom_range(0, 1023));
        switches = r[9:0];
        repeat (3) tick();
        rd(ADDR_SW_LO, d); check("sw_lo", d, r[7:0]);
        rd(ADDR_SW_HI, d); check("sw_hi", d, {6'b0, r[9:8]});

        // UART TX: three bytes, one in flight at a time
        start_log.delete();
        wr(ADDR_UART_TXD, 8'h11); txq.push_back(8'h11);
        wr(ADDR_UART_TXD, 8'h22); txq.push_back(8'h22);
        wr(ADDR_UART_TXD, 8'h33); txq.push_back(8'h33);
        for (int i = 0; i < 3; i++) begin
            wait_start(seen, d);
            check("tx_start_seen", seen, 1);
            check("tx_byte", d, txq.pop_front());
            repeat (3) tick();
            check("tx_no_start_while_busy", start_log.size(), 0);
            done_pulse();
        end
        rd(ADDR_UART_CTL, d); check("tx_ctl_end", d, ctl_exp());

        // TX overflow while the boot loader holds the line
        booting = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            wr(ADDR_UART_TXD, b);
            if (txq.size() < DEPTH) txq.push_back(b);
            else tx_ovf_m = 1'b1;
        end
        rd(ADDR_UART_CTL, d); check("tx_ovf_ctl", d, ctl_exp());
        boot_data = 8'($urandom);
        boot_tx = 1'b1;
        #1;
        check("boot_start", tx_start, 1);
        check("boot_data", tx_data, boot_data);
        tick();
        boot_tx = 1'b0;
        repeat (3) tick();
        check("boot_only_pulse", start_log.size(), 1);
        if (start_log.size() > 0) check("boot_logged", start_log.pop_front(), boot_data);
        start_log.delete();
        wr(ADDR_UART_CTL, 8'h10); tx_ovf_m = 1'b0;
        rd(ADDR_UART_CTL, d); check("tx_ovf_clear", d, ctl_exp());
        booting = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_start(seen, d);
            check("drain_seen", seen, 1);
            exp = txq.pop_front();
            check("drain_byte", d, exp);
            tick();
            done_pulse();
        end
        rd(ADDR_UART_CTL, d); check("drain_ctl", d, ctl_exp());

        // UART RX: fill, push with simultaneous pop, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'($urandom); rx_done = 1'b1;
            tick();
            rx_done = 1'b0;
            rxq.push_back(rx_data);
        end
        rd(ADDR_UART_CTL, d); check("rx_full_ctl", d, ctl_exp());
        b = 8'($urandom);
        rx_data = b; rx_done = 1'b1; bus.addr = ADDR_UART_RXD; bus.re = 1'b1;
        tick();
        rx_done = 1'b0; bus.re = 1'b0;
        check("rx_pop_with_push", bus.dout, rxq.pop_front());
        rxq.push_back(b);
        rd(ADDR_UART_CTL, d); check("rx_no_ovf", d, ctl_exp());
        rx_data = 8'($urandom); rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_ovf_m = 1'b1;
        rd(ADDR_UART_CTL, d); check("rx_ovf_ctl", d, ctl_exp());
        while (rxq.size() > 0) begin
            rd(ADDR_UART_RXD, d); check("rx_byte", d, rxq.pop_front());
        end
        rd(ADDR_UART_RXD, d); check("rx_empty_read", d, 0);
        wr(ADDR_UART_CTL, 8'h08); rx_ovf_m = 1'b0;
        rd(ADDR_UART_CTL, d); check("rx_ovf_clear", d, ctl_exp());

        // Keys: press edge, live state, interrupt, write-1-to-clear
        k = $urandom_range(0, 3);
        keys[k] = 1'b0;
        repeat (3) tick();
        rd(ADDR_KEY_EVT, d); check("key_evt_set", d, 8'(1 << k));
        rd(ADDR_KEY, d); check("key_live", d, 8'(1 << k));
        wr(ADDR_IRQ_EN, 8'h04);
        tick();
        check("irq_key", irq, IRQ_BUILD);
        rd(ADDR_IRQ_EN, d); check("irq_en_read", d, IRQ_BUILD ? 8'h04 : 8'h00);
        wr(ADDR_IRQ_EN, 8'h00);
        wr(ADDR_KEY_EVT, 8'(1 << k));
        rd(ADDR_KEY_EVT, d); check("key_evt_clear", d, 0);
        keys = 4'hF;
        repeat (4) tick();
        rd(ADDR_KEY_EVT, d); check("key_release_no_evt", d, 0);
        rd(ADDR_KEY, d); check("key_released", d, 0);

        // Reset during a transfer: late tx_done must not launch anything
        start_log.delete();
        wr(ADDR_UART_TXD, 8'($urandom));
        wait_start(seen, d);
        check("pre_reset_start", seen, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        done_pulse();
        repeat (3) tick();
        check("post_reset_no_start", start_log.size(), 0);
        rd(ADDR_UART_CTL, d); check("post_reset_ctl", d, 8'h22);
        check("post_reset_ledr", ledr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
